// File: rtl/master_alu_if.sv
// Operand/result bundle between the register bank, the ALU and the memory controller.
interface master_alu_if #(
  parameter int DATA_W = 32
);
  logic signed [DATA_W-1:0] Reg1;
  logic signed [DATA_W-1:0] Reg2;
  logic        [4:0]        IV_ShiftRor;
  logic        [15:0]       IV_Mov;
  logic        [3:0]        OpCode;
  logic        [3:0]        Cond;
  logic                     S;
  logic        [3:0]        Flag;
  logic signed [DATA_W-1:0] Result;
  logic        [3:0]        New_Flag;

  modport master (
    output Reg1, Reg2, IV_ShiftRor, IV_Mov, OpCode, Cond, S, Flag,
    input  Result, New_Flag
  );

  modport slave (
    input  Reg1, Reg2, IV_ShiftRor, IV_Mov, OpCode, Cond, S, Flag,
    output Result, New_Flag
  );
endinterface

// File: rtl/master_alu.sv
// Registered 32-bit conditional ALU producing Result and NZCV flags one clock after its inputs.
// Optional multiplier on opcode 0101 is enabled by defining ALU_MUL_EN; otherwise that opcode is a NOP.
module master_alu #(
  parameter int DATA_W = 32
) (
  input logic        Clk,
  input logic        Reset,
  master_alu_if.slave bus
);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_ORR = 4'h1, OP_EOR = 4'h2, OP_ADD = 4'h3,
    OP_SUB  = 4'h4, OP_MUL = 4'h5, OP_MOV = 4'h6, OP_MOVI = 4'h7,
    OP_LSL  = 4'h8, OP_LSR = 4'h9, OP_ASR = 4'hA, OP_ROR  = 4'hB,
    OP_CMP  = 4'hC, OP_TST = 4'hD, OP_LDR = 4'hE, OP_STR  = 4'hF
  } op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  logic [DATA_W-1:0] a, b;
  logic [4:0]        sh;
  logic [3:0]        flag_i;
  logic              fn, fz, fc, fv;
  op_e               op;
  cond_e             cond;

  assign a      = bus.Reg1;
  assign b      = bus.Reg2;
  assign sh     = bus.IV_ShiftRor;
  assign flag_i = bus.Flag;
  assign {fn, fz, fc, fv} = bus.Flag;
  assign op     = op_e'(bus.OpCode);
  assign cond   = cond_e'(bus.Cond);

  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        flag_q, flag_d;

  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      CC_EQ: cond_pass = fz;
      CC_NE: cond_pass = !fz;
      CC_CS: cond_pass = fc;
      CC_CC: cond_pass = !fc;
      CC_MI: cond_pass = fn;
      CC_PL: cond_pass = !fn;
      CC_VS: cond_pass = fv;
      CC_VC: cond_pass = !fv;
      CC_HI: cond_pass = fc && !fz;
      CC_LS: cond_pass = !fc || fz;
      CC_GE: cond_pass = (fn == fv);
      CC_LT: cond_pass = (fn != fv);
      CC_GT: cond_pass = !fz && (fn == fv);
      CC_LE: cond_pass = fz || (fn != fv);
      CC_AL: cond_pass = 1'b1;
      CC_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  // Shifters carry one guard bit so the last bit shifted out falls out as the carry.
  logic        [DATA_W:0]   add_w, sub_w, lsl_w, lsr_w;
  logic signed [DATA_W:0]   asr_w;
  logic        [DATA_W-1:0] ror_w;
  logic        [5:0]        ror_back;

  assign add_w    = {1'b0, a} + {1'b0, b};
  assign sub_w    = {1'b0, a} - {1'b0, b};
  assign lsl_w    = {1'b0, a} << sh;
  assign lsr_w    = {a, 1'b0} >> sh;
  assign asr_w    = $signed({a, 1'b0}) >>> sh;
  assign ror_back = 6'd32 - {1'b0, sh};
  assign ror_w    = (a >> sh) | (a << ror_back);

  logic [DATA_W-1:0] alu;
  logic              c_n, v_n, wr, s_ok, force_f;

  always_comb begin
    alu     = '0;
    c_n     = fc;
    v_n     = fv;
    wr      = 1'b0;
    s_ok    = 1'b0;
    force_f = 1'b0;
    case (op)
      OP_AND:  begin alu = a & b; wr = 1'b1; s_ok = 1'b1; end
      OP_ORR:  begin alu = a | b; wr = 1'b1; s_ok = 1'b1; end
      OP_EOR:  begin alu = a ^ b; wr = 1'b1; s_ok = 1'b1; end
      OP_ADD: begin
        alu  = add_w[DATA_W-1:0];
        c_n  = add_w[DATA_W];
        v_n  = (a[DATA_W-1] == b[DATA_W-1]) && (alu[DATA_W-1] != a[DATA_W-1]);
        wr   = 1'b1;
        s_ok = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu     = sub_w[DATA_W-1:0];
        c_n     = ~sub_w[DATA_W];
        v_n     = (a[DATA_W-1] != b[DATA_W-1]) && (alu[DATA_W-1] != a[DATA_W-1]);
        wr      = (op == OP_SUB);
        s_ok    = 1'b1;
        force_f = (op == OP_CMP);
      end
      OP_MUL: begin
`ifdef ALU_MUL_EN
        alu  = a * b;
        wr   = 1'b1;
        s_ok = 1'b1;
`else
        alu  = '0;
`endif
      end
      OP_MOV:  begin alu = b; wr = 1'b1; s_ok = 1'b1; end
      OP_MOVI: begin alu = {{(DATA_W-16){1'b0}}, bus.IV_Mov}; wr = 1'b1; s_ok = 1'b1; end
      OP_LSL: begin
        alu  = lsl_w[DATA_W-1:0];
        c_n  = (sh == '0) ? fc : lsl_w[DATA_W];
        wr   = 1'b1;
        s_ok = 1'b1;
      end
      OP_LSR: begin
        alu  = lsr_w[DATA_W:1];
        c_n  = (sh == '0) ? fc : lsr_w[0];
        wr   = 1'b1;
        s_ok = 1'b1;
      end
      OP_ASR: begin
        alu  = asr_w[DATA_W:1];
        c_n  = (sh == '0) ? fc : asr_w[0];
        wr   = 1'b1;
        s_ok = 1'b1;
      end
      OP_ROR: begin
        alu  = ror_w;
        c_n  = (sh == '0) ? fc : ror_w[DATA_W-1];
        wr   = 1'b1;
        s_ok = 1'b1;
      end
      OP_TST:  begin alu = a & b; force_f = 1'b1; end
      OP_LDR, OP_STR: begin alu = add_w[DATA_W-1:0]; wr = 1'b1; end
      default: alu = '0;
    endcase
  end

  always_comb begin
    result_d = result_q;
    flag_d   = flag_i;
    if (cond_pass) begin
      if (wr) result_d = alu;
      if ((s_ok && bus.S) || force_f)
        flag_d = {alu[DATA_W-1], (alu == '0), c_n, v_n};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      result_q <= '0;
      flag_q   <= '0;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.Result   = result_q;
  assign bus.New_Flag = flag_q;

endmodule

// File: tb/tb_master_alu.sv
// Self-checking bench for master_alu: scoreboard of expected {Result,New_Flag} plus directed constants.
module tb_master_alu;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  master_alu_if #(.DATA_W(32)) bus ();
  master_alu #(.DATA_W(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [35:0] sb[$];
  logic [31:0] prev_res = '0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  cnd;
    logic        s;
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [15:0] mv;
    logic [35:0] want;
  } row_t;

  function automatic logic [35:0] model(input logic [3:0] op, input logic [3:0] cnd, input logic s,
                                        input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh, input logic [15:0] mv, input logic [31:0] prev);
    logic n, z, c, v, pass, cout, vout, wres, setf;
    logic [31:0] r, tmp;
    logic [63:0] us;
    longint ss;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cnd)
      4'h0: pass = z;        4'h1: pass = !z;
      4'h2: pass = c;        4'h3: pass = !c;
      4'h4: pass = n;        4'h5: pass = !n;
      4'h6: pass = v;        4'h7: pass = !v;
      4'h8: pass = c & !z;   4'h9: pass = !c | z;
      4'hA: pass = (n == v); 4'hB: pass = (n != v);
      4'hC: pass = !z & (n == v);
      4'hD: pass = z | (n != v);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    if (!pass) return {prev, f};
    cout = c; vout = v; wres = 1'b1; setf = s; r = '0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a ^ b;
      4'h3, 4'hE, 4'hF: begin
        us   = {32'b0, a} + {32'b0, b};
        r    = us[31:0];
        cout = us[32];
        ss   = longint'($signed(a)) + longint'($signed(b));
        vout = (ss > SMAX) || (ss < SMIN);
        if (op != 4'h3) begin setf = 1'b0; end
      end
      4'h4, 4'hC: begin
        us   = {32'b0, a} - {32'b0, b};
        r    = us[31:0];
        cout = (a >= b);
        ss   = longint'($signed(a)) - longint'($signed(b));
        vout = (ss > SMAX) || (ss < SMIN);
        if (op == 4'hC) begin wres = 1'b0; setf = 1'b1; end
      end
      4'h5: begin
`ifdef ALU_MUL_EN
        ss = longint'($signed(a)) * longint'($signed(b));
        r  = ss[31:0];
`else
        return {prev, f};
`endif
      end
      4'h6: r = b;
      4'h7: r = {16'b0, mv};
      4'h8, 4'h9, 4'hA, 4'hB: begin
        tmp = a;
        for (int i = 0; i < int'(sh); i++) begin
          case (op)
            4'h8:    begin cout = tmp[31]; tmp = {tmp[30:0], 1'b0}; end
            4'h9:    begin cout = tmp[0];  tmp = {1'b0, tmp[31:1]}; end
            4'hA:    begin cout = tmp[0];  tmp = {tmp[31], tmp[31:1]}; end
            default: begin cout = tmp[0];  tmp = {tmp[0], tmp[31:1]}; end
          endcase
        end
        r = tmp;
      end
      4'hD: begin r = a & b; wres = 1'b0; setf = 1'b1; end
      default: r = '0;
    endcase
    return {(wres ? r : prev), (setf ? {r[31], (r == 32'd0), cout, vout} : f)};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [3:0] cnd, input logic s, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh, input logic [15:0] mv);
    logic [35:0] e;
    @(negedge Clk);
    bus.OpCode = op; bus.Cond = cnd; bus.S = s; bus.Flag = f;
    bus.Reg1 = a; bus.Reg2 = b; bus.IV_ShiftRor = sh; bus.IV_Mov = mv;
    e = model(op, cnd, s, f, a, b, sh, mv, prev_res);
    prev_res = e[35:4];
    sb.push_back(e);
  endtask

  task automatic test_reset();
    bus.OpCode = 4'h3; bus.Cond = 4'hE; bus.S = 1'b1; bus.Flag = 4'hF;
    bus.Reg1 = 32'h1234_5678; bus.Reg2 = 32'h1111_1111; bus.IV_ShiftRor = 5'd3; bus.IV_Mov = 16'hAAAA;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++;
    if (bus.Result !== 32'd0) begin
      n_bad++; $display("FAIL reset_result: got %h want 00000000", bus.Result);
    end
    n_cmp++;
    if (bus.New_Flag !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", bus.New_Flag);
    end
    @(negedge Clk);
    Reset = 1'b1;
    prev_res = '0;
  endtask

  task automatic run_directed(input row_t t[], input string tag);
    logic [35:0] e;
    foreach (t[k]) begin
      issue(t[k].op, t[k].cnd, t[k].s, t[k].f, t[k].a, t[k].b, t[k].sh, t[k].mv);
      @(posedge Clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({bus.Result, bus.New_Flag} !== e) begin
        n_bad++;
        $display("FAIL %s[%0d] model: got %h/%b want %h/%b", tag, k, bus.Result, bus.New_Flag, e[35:4], e[3:0]);
      end
      n_cmp++;
      if ({bus.Result, bus.New_Flag} !== t[k].want) begin
        n_bad++;
        $display("FAIL %s[%0d] const: got %h/%b want %h/%b", tag, k, bus.Result, bus.New_Flag,
                 t[k].want[35:4], t[k].want[3:0]);
      end
    end
  endtask

  task automatic test_arith();
    row_t t[];
    t = new[5];
    t[0] = '{4'h3, 4'hE, 1'b1, 4'h0, 32'd5, 32'd7, 5'd0, 16'h0, {32'd12, 4'b0000}};
    t[1] = '{4'h4, 4'hE, 1'b1, 4'h0, 32'd3, 32'd3, 5'd0, 16'h0, {32'd0, 4'b0110}};
    t[2] = '{4'hC, 4'hE, 1'b0, 4'h0, 32'd2, 32'd5, 5'd0, 16'h0, {32'd0, 4'b1000}};
    t[3] = '{4'h3, 4'hE, 1'b1, 4'h0, 32'h7FFF_FFFF, 32'd1, 5'd0, 16'h0, {32'h8000_0000, 4'b1001}};
    t[4] = '{4'h3, 4'hE, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'd1, 5'd0, 16'h0, {32'd0, 4'b0110}};
    run_directed(t, "arith");
  endtask

  task automatic test_cond();
    row_t t[];
    logic [35:0] e;
    t = new[4];
    t[0] = '{4'h7, 4'hE, 1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 16'h1234, {32'h0000_1234, 4'b0000}};
    t[1] = '{4'h3, 4'h0, 1'b1, 4'h0, 32'd1, 32'd1, 5'd0, 16'h0, {32'h0000_1234, 4'b0000}};
    t[2] = '{4'h3, 4'h0, 1'b0, 4'h4, 32'd1, 32'd1, 5'd0, 16'h0, {32'd2, 4'b0100}};
    t[3] = '{4'h6, 4'hF, 1'b1, 4'h9, 32'd0, 32'd9, 5'd0, 16'h0, {32'd2, 4'b1001}};
    run_directed(t, "cond");
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f += 5) begin
        issue(4'h7, 4'(c), 1'b0, 4'(f), 32'd0, 32'd0, 5'd0, 16'(c * 16 + f + 1));
        @(posedge Clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if ({bus.Result, bus.New_Flag} !== e) begin
          n_bad++;
          $display("FAIL cond_sweep c=%0d f=%0d: got %h/%b want %h/%b", c, f, bus.Result, bus.New_Flag,
                   e[35:4], e[3:0]);
        end
      end
    end
  endtask

  task automatic test_shift_movi();
    row_t t[];
    t = new[6];
    t[0] = '{4'h7, 4'hE, 1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 16'hBEEF, {32'h0000_BEEF, 4'b0000}};
    t[1] = '{4'h8, 4'hE, 1'b1, 4'h0, 32'h8000_0001, 32'd0, 5'd1, 16'h0, {32'd2, 4'b0010}};
    t[2] = '{4'hB, 4'hE, 1'b1, 4'h0, 32'd1, 32'd0, 5'd1, 16'h0, {32'h8000_0000, 4'b1010}};
    t[3] = '{4'hA, 4'hE, 1'b1, 4'h0, 32'h8000_0000, 32'd0, 5'd4, 16'h0, {32'hF800_0000, 4'b1000}};
    t[4] = '{4'h8, 4'hE, 1'b1, 4'h3, 32'h4000_0000, 32'd0, 5'd0, 16'h0, {32'h4000_0000, 4'b0011}};
    t[5] = '{4'h9, 4'hE, 1'b1, 4'h0, 32'h0000_0003, 32'd0, 5'd1, 16'h0, {32'h0000_0001, 4'b0010}};
    run_directed(t, "shift");
  endtask

  task automatic test_mul();
    row_t t[];
    t = new[3];
    t[0] = '{4'h7, 4'hE, 1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 16'h0055, {32'h0000_0055, 4'b0000}};
`ifdef ALU_MUL_EN
    t[1] = '{4'h5, 4'hE, 1'b1, 4'h5, 32'hFFFF_FFFD, 32'd7, 5'd0, 16'h0, {32'hFFFF_FFEB, 4'b1001}};
    t[2] = '{4'h5, 4'hF, 1'b1, 4'h2, 32'd6, 32'd7, 5'd0, 16'h0, {32'hFFFF_FFEB, 4'b0010}};
`else
    t[1] = '{4'h5, 4'hE, 1'b1, 4'h5, 32'hFFFF_FFFD, 32'd7, 5'd0, 16'h0, {32'h0000_0055, 4'b0101}};
    t[2] = '{4'h5, 4'hF, 1'b1, 4'h2, 32'd6, 32'd7, 5'd0, 16'h0, {32'h0000_0055, 4'b0010}};
`endif
    run_directed(t, "mul");
  endtask

  task automatic test_addr();
    row_t t[];
    t = new[3];
    t[0] = '{4'hE, 4'hE, 1'b1, 4'h6, 32'h0000_1000, 32'h0000_0024, 5'd0, 16'h0, {32'h0000_1024, 4'b0110}};
    t[1] = '{4'hF, 4'hE, 1'b1, 4'h9, 32'hFFFF_FFFC, 32'd8, 5'd0, 16'h0, {32'h0000_0004, 4'b1001}};
    t[2] = '{4'hD, 4'hE, 1'b0, 4'h3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, 16'h0, {32'h0000_0004, 4'b0111}};
    run_directed(t, "addr_tst");
  endtask

  task automatic test_back_to_back();
    logic [35:0] e;
    logic [31:0] a, b;
    for (int k = 0; k < 300; k++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, b,
            5'($urandom_range(0, 31)), 16'($urandom));
      @(posedge Clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({bus.Result, bus.New_Flag} !== e) begin
        n_bad++;
        $display("FAIL b2b[%0d] op=%h cond=%h: got %h/%b want %h/%b", k, bus.OpCode, bus.Cond,
                 bus.Result, bus.New_Flag, e[35:4], e[3:0]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [35:0] e;
    issue(4'h7, 4'hE, 1'b1, 4'h0, 32'd0, 32'd0, 5'd0, 16'h0077);
    @(posedge Clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if ({bus.Result, bus.New_Flag} !== e) begin
      n_bad++; $display("FAIL pre_reset: got %h/%b want %h/%b", bus.Result, bus.New_Flag, e[35:4], e[3:0]);
    end
    #1 Reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.Result, bus.New_Flag} !== 36'd0) begin
      n_bad++; $display("FAIL async_reset: got %h/%b want 00000000/0000", bus.Result, bus.New_Flag);
    end
    @(negedge Clk);
    Reset = 1'b1;
    prev_res = '0;
    issue(4'h3, 4'hE, 1'b1, 4'h0, 32'd5, 32'd7, 5'd0, 16'h0);
    @(posedge Clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if ({bus.Result, bus.New_Flag} !== {32'd12, 4'b0000} || e !== {32'd12, 4'b0000}) begin
      n_bad++; $display("FAIL post_release: got %h/%b want 0000000c/0000", bus.Result, bus.New_Flag);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_cond();
    test_shift_movi();
    test_mul();
    test_addr();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
